// File: rtl/dal_seq_pkg.sv
// Shared types and constants for the DAL stage-2 run sequencer.
package dal_seq_pkg;
  localparam int PARA   = 8;
  localparam int NSTAGE = 7;

  typedef enum logic [2:0] {IDLE, CALC, CLEAR, RUN, DRAIN} seq_state_e;
  typedef logic [PARA-1:0] step_t;

  // Stage value meaning "all stages consumed".
  localparam logic [2:0] STAGE_FIN = 3'd7;
endpackage

// File: rtl/dal_boundary_acc.sv
// Serial prefix-sum of stage lengths: one boundary per enabled cycle,
// with the config check evaluated on the last stage.
module dal_boundary_acc
  import dal_seq_pkg::*;
#(
  parameter int PARA   = dal_seq_pkg::PARA,
  parameter int NSTAGE = dal_seq_pkg::NSTAGE
) (
  input  logic                         CLK_i,
  input  logic                         RST_ni,
  input  logic                         init_i,
  input  logic                         en_i,
  input  logic [NSTAGE-1:0][PARA-1:0]  len_i,
  output logic [NSTAGE-1:0][PARA-1:0]  boundary_o,
  output logic                         last_o,
  output logic                         err_o
);
  // Three guard bits hold the sum of up to 8 PARA-bit lengths without wrap.
  localparam int AW = PARA + 3;
  localparam int KW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  logic [AW-1:0] acc, acc_new;
  logic [KW-1:0] k;

  // Running sum including the current stage; overflow is judged on the final sum.
  always_comb begin
    acc_new = acc + AW'(len_i[k]);
    last_o  = (k == KW'(NSTAGE-1));
    err_o   = last_o && ((len_i[0] == '0) || (acc_new > AW'((1 << PARA) - 1)));
  end

  // Accumulator, stage index and boundary registers.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      acc        <= '0;
      k          <= '0;
      boundary_o <= '0;
    end else if (init_i) begin
      acc <= '0;
      k   <= '0;
    end else if (en_i) begin
      acc           <= acc_new;
      boundary_o[k] <= acc_new[PARA-1:0] - PARA'(1);
      if (!last_o) k <= k + KW'(1);
    end
  end
endmodule

// File: rtl/dal_stage_sequencer.sv
// Run-level controller for the DAL stage-2 datapath: computes stage
// boundaries, clears the pipe, drives the stall from the handshake and
// mirrors the datapath step/stage counters.
module dal_stage_sequencer
  import dal_seq_pkg::*;
#(
  parameter int PARA      = dal_seq_pkg::PARA,
  parameter int NSTAGE    = dal_seq_pkg::NSTAGE,
  parameter int WIDTH     = 16,
  parameter int DRAIN_LAT = 2
) (
  input  logic                         CLK_i,
  input  logic                         RST_ni,
  input  logic                         start_i,
  input  logic [NSTAGE-1:0][PARA-1:0]  cfg_len_i,
  input  logic                         in_valid_i,
  input  logic                         out_ready_i,
  input  logic                         finished_i,
  output logic [NSTAGE-1:0][PARA-1:0]  stage_boundary_o,
  output logic                         pipe_clr_o,
  output logic                         stall_o,
  output logic [2:0]                   stage_o,
  output logic [PARA-1:0]              step_o,
  output logic [WIDTH-1:0]             pos_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_err_o,
  output logic                         sync_err_o
);
  localparam int DW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

  seq_state_e                  state, state_nxt;
  logic [NSTAGE-1:0][PARA-1:0] len_q;
  logic [DW-1:0]               drain_cnt;
  logic [2:0]                  stage_cnt;
  logic                        acc_init, acc_en, acc_last, acc_err;
  logic                        adv, chk_pend;

  dal_boundary_acc #(.PARA(PARA), .NSTAGE(NSTAGE)) u_acc (
    .CLK_i      (CLK_i),
    .RST_ni     (RST_ni),
    .init_i     (acc_init),
    .en_i       (acc_en),
    .len_i      (len_q),
    .boundary_o (stage_boundary_o),
    .last_o     (acc_last),
    .err_o      (acc_err)
  );

  // Next stage = number of boundaries the current (pre-increment) step lies past.
  always_comb begin
    stage_cnt = '0;
    for (int k = 0; k < NSTAGE; k++)
      stage_cnt = stage_cnt + 3'(step_o > stage_boundary_o[k]);
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b1;
    busy_o     = (state != IDLE);
    pipe_clr_o = 1'b0;
    done_o     = 1'b0;
    acc_init   = 1'b0;
    acc_en     = 1'b0;
    case (state)
      IDLE:  if (start_i) begin
               acc_init  = 1'b1;
               state_nxt = CALC;
             end
      CALC:  begin
               acc_en = 1'b1;
               if (acc_last) state_nxt = acc_err ? IDLE : CLEAR;
             end
      CLEAR: begin
               pipe_clr_o = 1'b1;
               state_nxt  = RUN;
             end
      RUN:   if (stage_o == STAGE_FIN) state_nxt = DRAIN;
             else stall_o = !(in_valid_i && out_ready_i);
      DRAIN: if (drain_cnt == DW'(DRAIN_LAT-1)) begin
               done_o    = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign adv = (state == RUN) && !stall_o;

  // State register, mirrored counters, drain timer and error flags.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state      <= IDLE;
      len_q      <= '0;
      step_o     <= '0;
      stage_o    <= '0;
      pos_o      <= '0;
      drain_cnt  <= '0;
      chk_pend   <= 1'b0;
      cfg_err_o  <= 1'b0;
      sync_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      chk_pend <= adv;
      if (state == IDLE && start_i) begin
        len_q      <= cfg_len_i;
        cfg_err_o  <= 1'b0;
        sync_err_o <= 1'b0;
      end
      if (state == CALC && acc_err) cfg_err_o <= 1'b1;
      if (state == CLEAR) begin
        step_o  <= '0;
        stage_o <= '0;
        pos_o   <= '0;
      end
      if (adv) begin
        step_o  <= step_o + PARA'(1);
        stage_o <= stage_cnt;
        pos_o   <= (stage_cnt != stage_o) ? '0 : pos_o + WIDTH'(1);
      end
      // Cross-check the datapath's finished flag one cycle after each step.
      if (state == RUN && chk_pend && (finished_i != (stage_o == STAGE_FIN)))
        sync_err_o <= 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_dal_stage_sequencer.sv
// Scoreboard bench for dal_stage_sequencer: the stimulus side predicts
// boundaries and the per-step trace; a negedge monitor pops and compares.
module tb_dal_stage_sequencer;
  typedef logic [6:0][7:0] lens_t;
  typedef struct packed {
    logic [7:0]  step;
    logic [2:0]  stage;
    logic [15:0] pos;
  } exp_t;

  logic        CLK_i = 1'b0, RST_ni = 1'b0;
  logic        start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0, finished_i;
  lens_t       cfg_len_i = '0;
  lens_t       stage_boundary_o;
  logic        pipe_clr_o, stall_o, busy_o, done_o, cfg_err_o, sync_err_o;
  logic [2:0]  stage_o;
  logic [7:0]  step_o;
  logic [15:0] pos_o;

  logic  fin_force = 1'b0;
  exp_t  exp_q[$];
  lens_t bnd_q[$];
  int    n_tests = 0, n_fail = 0, done_cnt = 0, clr_cnt = 0;
  bit    prev_adv = 0;
  exp_t  mon_e;
  lens_t mon_b;

  assign finished_i = fin_force | (stage_o == 3'd7);

  always #5 CLK_i = ~CLK_i;

  dal_stage_sequencer dut (
    .CLK_i(CLK_i), .RST_ni(RST_ni), .start_i(start_i), .cfg_len_i(cfg_len_i),
    .in_valid_i(in_valid_i), .out_ready_i(out_ready_i), .finished_i(finished_i),
    .stage_boundary_o(stage_boundary_o), .pipe_clr_o(pipe_clr_o), .stall_o(stall_o),
    .stage_o(stage_o), .step_o(step_o), .pos_o(pos_o), .busy_o(busy_o),
    .done_o(done_o), .cfg_err_o(cfg_err_o), .sync_err_o(sync_err_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lens_t mk(input int a, b, c, d, e, f, g);
    lens_t l;
    l[0] = 8'(a); l[1] = 8'(b); l[2] = 8'(c); l[3] = 8'(d);
    l[4] = 8'(e); l[5] = 8'(f); l[6] = 8'(g);
    return l;
  endfunction

  // Monitor: compare the mirrored counters after every unstalled RUN cycle,
  // and the boundary set whenever the pipe clear is issued.
  always @(negedge CLK_i) begin
    if (!RST_ni) prev_adv = 0;
    else begin
      if (prev_adv) begin
        if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("step_stage_pos", {step_o, stage_o, pos_o}, mon_e);
        end
      end
      if (pipe_clr_o) begin
        clr_cnt++;
        if (bnd_q.size() == 0) chk("unexpected_clear", 1, 0);
        else begin
          mon_b = bnd_q.pop_front();
          chk("boundaries", stage_boundary_o, mon_b);
        end
      end
      if (done_o) done_cnt++;
      prev_adv = busy_o && !stall_o;
    end
  end

  task automatic chk_reset_state(input string name);
    chk(name, {stall_o, pipe_clr_o, busy_o, done_o, cfg_err_o, sync_err_o,
               stage_o, step_o, pos_o, stage_boundary_o},
              {1'b1, 5'b0, 3'd0, 8'd0, 16'd0, 56'd0});
  endtask

  // Issue one run. Model: cum[k] are stage start positions; step s lies in
  // stage (#k>=1 with cum[k] <= s). Each unstalled step from s reports
  // step s+1 and the stage of s; the run ends once the stage reaches 7.
  task automatic run_case(input lens_t lens, input int mode, input int abort_at,
                          input int force_stg, input bit poke_start);
    int cum[8];
    bit err, poked;
    int dn0, clr0, cyc, stg, prev_stg, pos;
    lens_t b;
    exp_t e;
    cum[0] = 0;
    for (int k = 0; k < 7; k++) cum[k+1] = cum[k] + int'(lens[k]);
    err = (lens[0] == 0) || (cum[7] > 255);
    if (!err) begin
      for (int k = 0; k < 7; k++) b[k] = 8'(cum[k+1] - 1);
      bnd_q.push_back(b);
      prev_stg = 0; pos = 0;
      for (int s = 0; s <= cum[7]; s++) begin
        stg = 0;
        for (int k = 1; k <= 7; k++) if (cum[k] <= s) stg++;
        pos = (stg != prev_stg) ? 0 : pos + 1;
        prev_stg = stg;
        e.step = 8'(s + 1); e.stage = 3'(stg); e.pos = 16'(pos);
        exp_q.push_back(e);
      end
    end
    dn0 = done_cnt; clr0 = clr_cnt; poked = 0;
    @(posedge CLK_i); #1;
    cfg_len_i = lens; start_i = 1'b1;
    @(posedge CLK_i); #1;
    start_i = 1'b0; cfg_len_i = lens_t'({$urandom, $urandom});
    cyc = 0;
    while (cyc < 3000) begin
      case (mode)
        0: begin in_valid_i = 1; out_ready_i = 1; end
        1: begin in_valid_i = 1; out_ready_i = (cyc % 3 != 2); end
        default: begin in_valid_i = ($urandom_range(0, 3) != 0); out_ready_i = ($urandom_range(0, 3) != 0); end
      endcase
      start_i = 1'b0;
      @(negedge CLK_i);
      if (!busy_o) break;
      if (abort_at >= 0 && step_o == 8'(abort_at)) begin
        #2 RST_ni = 1'b0;
        exp_q.delete(); bnd_q.delete();
        @(negedge CLK_i);
        chk_reset_state("reset_midrun");
        repeat (3) @(negedge CLK_i);
        chk("no_done_after_abort", done_cnt, dn0);
        @(posedge CLK_i); #1 RST_ni = 1'b1;
        return;
      end
      if (force_stg >= 0 && stage_o == 3'(force_stg)) fin_force = 1'b1;
      cyc++;
      @(posedge CLK_i); #1;
      if (poke_start && !poked && stage_o == 3'd1) begin
        start_i = 1'b1; poked = 1;
      end
    end
    start_i = 1'b0;
    if (cyc >= 3000) begin
      chk("run_timeout", cyc, 0);
      return;
    end
    if (err) begin
      chk("cfg_err_set", cfg_err_o, 1);
      chk("no_clear_on_err", clr_cnt, clr0);
      chk("no_done_on_err", done_cnt, dn0);
    end else begin
      chk("done_once", done_cnt, dn0 + 1);
      chk("trace_consumed", exp_q.size(), 0);
      chk("cfg_err_clear", cfg_err_o, 0);
      chk("sync_err", sync_err_o, (force_stg >= 0));
      chk("final_stage", stage_o, 3'd7);
    end
    repeat (2) @(negedge CLK_i);
    chk("idle_after_run", {busy_o, stall_o}, 2'b01);
  endtask

  initial begin
    lens_t l;
    #23;
    chk_reset_state("reset_state");
    RST_ni = 1'b1;

    // 1: ascending lengths, free-running handshake
    run_case(mk(1, 2, 3, 4, 5, 6, 7), 0, -1, -1, 0);
    chk("case1_bounds", stage_boundary_o, mk(0, 2, 5, 9, 14, 20, 27));
    // 2: same, out_ready low every third cycle
    run_case(mk(1, 2, 3, 4, 5, 6, 7), 1, -1, -1, 0);
    // 3: zero-length stages skipped
    run_case(mk(4, 0, 0, 2, 1, 1, 1), 2, -1, -1, 0);
    chk("case3_bounds", stage_boundary_o, mk(3, 3, 3, 5, 6, 7, 8));
    // 4: overflow -> cfg error, then len[0]==0 -> cfg error
    run_case(mk(200, 60, 0, 0, 0, 0, 0), 0, -1, -1, 0);
    run_case(mk(0, 5, 5, 0, 0, 0, 0), 2, -1, -1, 0);
    // boundary: sum exactly 255 is legal
    run_case(mk(200, 55, 0, 0, 0, 0, 0), 0, -1, -1, 0);
    // 5: reset mid-run, then a clean run
    run_case(mk(1, 2, 3, 4, 5, 6, 7), 0, 10, -1, 0);
    run_case(mk(1, 2, 3, 4, 5, 6, 7), 0, -1, -1, 0);
    // 6: forced finished flag and an ignored start during RUN
    run_case(mk(2, 3, 4, 1, 2, 3, 1), 2, -1, 2, 1);
    fin_force = 1'b0;
    repeat (3) @(negedge CLK_i);
    chk("sync_err_sticky", sync_err_o, 1);
    // randomized runs (the first also shows sync_err cleared by start)
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 7; k++) l[k] = 8'($urandom_range(0, 20));
      if (r != 7) l[0] = 8'($urandom_range(1, 20));
      else l[0] = 8'd0;
      run_case(l, int'($urandom_range(0, 2)), -1, -1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
